truth_table_checker: RTL and testbench

TRUTH_TABLE_CHECKER -- requirements
Module: truth_table_checker

---
 rtl/truth_table_checker.sv | 104 ++++++++++
 tb/tb_truth_table_checker.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/truth_table_checker.sv
// Truth-table sweeper for a 2-input unit: drives each input vector for
// HOLD_CYCLES clocks, samples the response on the last hold cycle and
// accumulates a per-vector mismatch map, a mismatch count and a pass flag.
module truth_table_checker #(
  parameter int         HOLD_CYCLES = 100,
  parameter logic [3:0] EXPECTED    = 4'b1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       dut_a,
  output logic       dut_b,
  input  logic       dut_c,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_vec
);

  // state | meaning
  // IDLE  | waiting for start, stimulus held at 00
  // HOLD  | driving vector index, counting hold cycles
  // DONE  | one-cycle done pulse, results final

  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, HOLD, DONE} state_t;

  state_t        state;
  logic [1:0]    index;
  logic [CW-1:0] cnt;
  logic          mismatch;

  // Response is only meaningful on the last hold cycle; qualified in the FSM.
  assign mismatch = (dut_c != EXPECTED[index]);

  // Sweep sequencer with registered stimulus and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      index     <= 2'd0;
      cnt       <= '0;
      dut_a     <= 1'b0;
      dut_b     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= 3'd0;
      fail_vec  <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state     <= HOLD;
            busy      <= 1'b1;
            index     <= 2'd0;
            cnt       <= '0;
            dut_a     <= 1'b0;
            dut_b     <= 1'b0;
            pass      <= 1'b0;
            err_count <= 3'd0;
            fail_vec  <= 4'd0;
          end
        end
        HOLD: begin
          if (cnt == LAST) begin
            if (mismatch) begin
              fail_vec[index] <= 1'b1;
              err_count       <= err_count + 3'd1;
            end
            cnt <= '0;
            if (index == 2'd3) begin
              state <= DONE;
              done  <= 1'b1;
              // Fold in the final compare, which err_count has not seen yet.
              pass  <= !mismatch && (err_count == 3'd0);
              dut_a <= 1'b0;
              dut_b <= 1'b0;
            end else begin
              index          <= index + 2'd1;
              {dut_a, dut_b} <= index + 2'd1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_checker.sv
// Directed bench: two checker instances (HOLD_CYCLES=4 and 1) each driving a
// small behavioural unit (AND, OR or stuck-at-0) with hand-computed results.
module tb_truth_table_checker;

  localparam int H4 = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start4 = 1'b0, start1 = 1'b0;
  logic       a4, b4, c4, busy4, done4, pass4;
  logic       a1, b1, c1, busy1, done1, pass1;
  logic [2:0] err4, err1;
  logic [3:0] fv4, fv1;
  int         mode4 = 0, mode1 = 2;   // 0 AND, 1 OR, 2 stuck-at-0
  int         nvec = 0, nerr = 0;

  always #5 clk = ~clk;

  assign c4 = (mode4 == 0) ? (a4 & b4) : (mode4 == 1) ? (a4 | b4) : 1'b0;
  assign c1 = (mode1 == 0) ? (a1 & b1) : (mode1 == 1) ? (a1 | b1) : 1'b0;

  truth_table_checker #(.HOLD_CYCLES(H4), .EXPECTED(4'b1000)) u_h4 (
    .clk(clk), .rst(rst), .start(start4), .dut_a(a4), .dut_b(b4), .dut_c(c4),
    .busy(busy4), .done(done4), .pass(pass4), .err_count(err4), .fail_vec(fv4));

  truth_table_checker #(.HOLD_CYCLES(1), .EXPECTED(4'b1000)) u_h1 (
    .clk(clk), .rst(rst), .start(start1), .dut_a(a1), .dut_b(b1), .dut_c(c1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .fail_vec(fv1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one sweep on the H4 instance; start is re-pulsed during cycles rp_a/rp_b
  // (0 = none). Returns the cycle of the first done pulse and the pulse count.
  task automatic sweep4(input int rp_a, input int rp_b, output int dcyc, output int npulse);
    @(negedge clk);
    start4 = 1'b1;
    @(posedge clk);
    #1 start4 = 1'b0;
    chk("clr_err", 32'(err4), 32'd0);
    chk("clr_fv", 32'(fv4), 32'd0);
    chk("clr_pass", 32'(pass4), 32'd0);
    dcyc   = 0;
    npulse = 0;
    for (int n = 1; n <= 4 * H4 + 10; n++) begin
      if (n == rp_a || n == rp_b) start4 = 1'b1;
      @(posedge clk);
      #1 start4 = 1'b0;
      chk("busy", 32'(busy4), (n <= 4 * H4) ? 32'd1 : 32'd0);
      chk("ab", 32'({a4, b4}), (n < 4 * H4) ? 32'(n / H4) : 32'd0);
      if (done4) begin
        npulse++;
        if (dcyc == 0) dcyc = n + 1;
      end
    end
  endtask

  initial begin
    int dcyc, np, d1, cnt_done;

    #12;
    chk("rst_busy", 32'(busy4), 32'd0);
    chk("rst_done", 32'(done4), 32'd0);
    chk("rst_pass", 32'(pass4), 32'd0);
    chk("rst_err", 32'(err4), 32'd0);
    chk("rst_fv", 32'(fv4), 32'd0);
    chk("rst_ab", 32'({a4, b4}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // AND unit: every vector matches
    mode4 = 0;
    sweep4(0, 0, dcyc, np);
    chk("and_done_cyc", 32'(dcyc), 32'd17);
    chk("and_npulse", 32'(np), 32'd1);
    chk("and_pass", 32'(pass4), 32'd1);
    chk("and_err", 32'(err4), 32'd0);
    chk("and_fv", 32'(fv4), 32'b0000);

    // OR unit: vectors 01 and 10 mismatch
    mode4 = 1;
    sweep4(0, 0, dcyc, np);
    chk("or_done_cyc", 32'(dcyc), 32'd17);
    chk("or_pass", 32'(pass4), 32'd0);
    chk("or_err", 32'(err4), 32'd2);
    chk("or_fv", 32'(fv4), 32'b0110);
    repeat (5) @(negedge clk);
    chk("or_hold_err", 32'(err4), 32'd2);
    chk("or_hold_fv", 32'(fv4), 32'b0110);

    // AND after a failing sweep: results cleared and rebuilt
    mode4 = 0;
    sweep4(0, 0, dcyc, np);
    chk("reand_done_cyc", 32'(dcyc), 32'd17);
    chk("reand_pass", 32'(pass4), 32'd1);
    chk("reand_err", 32'(err4), 32'd0);
    chk("reand_fv", 32'(fv4), 32'b0000);

    // HOLD_CYCLES=1, stuck-at-0 unit: only vector 11 mismatches
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    d1 = 0;
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk);
      #1;
      if (done1 && d1 == 0) d1 = n + 1;
    end
    chk("h1_done_cyc", 32'(d1), 32'd5);
    chk("h1_err", 32'(err1), 32'd1);
    chk("h1_fv", 32'(fv1), 32'b1000);
    chk("h1_pass", 32'(pass1), 32'd0);

    // Reset during vector 10 of an OR sweep
    mode4 = 1;
    @(negedge clk);
    start4 = 1'b1;
    @(posedge clk);
    #1 start4 = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("pre_rst_ab", 32'({a4, b4}), 32'b10);
    chk("pre_rst_err", 32'(err4), 32'd1);
    rst = 1'b1;
    #1;
    chk("async_busy", 32'(busy4), 32'd0);
    chk("async_err", 32'(err4), 32'd0);
    chk("async_fv", 32'(fv4), 32'd0);
    chk("async_ab", 32'({a4, b4}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cnt_done = 0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk);
      #1;
      if (done4) cnt_done++;
    end
    chk("post_rst_done", 32'(cnt_done), 32'd0);
    chk("post_rst_busy", 32'(busy4), 32'd0);
    chk("post_rst_pass", 32'(pass4), 32'd0);
    chk("post_rst_err", 32'(err4), 32'd0);
    chk("post_rst_fv", 32'(fv4), 32'd0);
    mode4 = 0;
    sweep4(0, 0, dcyc, np);
    chk("fresh_done_cyc", 32'(dcyc), 32'd17);
    chk("fresh_pass", 32'(pass4), 32'd1);

    // Start re-pulsed mid-sweep is ignored
    sweep4(3, 9, dcyc, np);
    chk("rp_done_cyc", 32'(dcyc), 32'd17);
    chk("rp_npulse", 32'(np), 32'd1);
    chk("rp_pass", 32'(pass4), 32'd1);
    chk("rp_err", 32'(err4), 32'd0);
    chk("rp_fv", 32'(fv4), 32'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
